// File: rtl/gpio_cmd_pkg.sv
// ---------------------------------------------------------------------------
// gpio_cmd_pkg
// Shared types and constants for the GPIO command bridge.
//   gpio_cmd_state_t    : decoder FSM states
//   GPIO_CMD_MODE_RESET : gpio_mode[7:0] after reset (pins 0/1 outputs)
//   GPIO_CMD_DATA_RESET : gpio_data[7:0] after reset
//   GPIO_CMD_DROP_MAX   : saturation value of the dropped-byte counter
// ---------------------------------------------------------------------------
package gpio_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        APPLY,
        SETTLE,
        SAMPLE,
        SEND
    } gpio_cmd_state_t;

    localparam logic [7:0] GPIO_CMD_MODE_RESET = 8'h03;
    localparam logic [7:0] GPIO_CMD_DATA_RESET = 8'h01;
    localparam logic [7:0] GPIO_CMD_DROP_MAX   = 8'hFF;

    // Saturating increment for the dropped-byte counter.
    function automatic logic [7:0] drop_inc(input logic [7:0] value);
        return (value == GPIO_CMD_DROP_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/gpio_cmd_bridge_if.sv
// ---------------------------------------------------------------------------
// gpio_cmd_bridge_if
// Groups the byte-stream, GPIO and status-return signals of the bridge.
//   rx_data/rx_valid           : received byte and its one-cycle strobe
//   gpio_mode/gpio_data        : GPIO direction (1 = output) and levels
//   gpio_valid                 : one-cycle GPIO write strobe
//   gpio_rd                    : pin levels read back from GPIO
//   tx_data/tx_valid/tx_ready  : status byte handshake towards TX
// Modports:
//   master : the surrounding system (RX, GPIO, TX side)
//   slave  : the bridge itself
// ---------------------------------------------------------------------------
interface gpio_cmd_bridge_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] gpio_mode;
    logic [31:0] gpio_data;
    logic        gpio_valid;
    logic [31:0] gpio_rd;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output rx_data, rx_valid, gpio_rd, tx_ready,
        input  gpio_mode, gpio_data, gpio_valid, tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, gpio_rd, tx_ready,
        output gpio_mode, gpio_data, gpio_valid, tx_data, tx_valid
    );

endinterface

// File: rtl/gpio_cmd_timer.sv
// ---------------------------------------------------------------------------
// gpio_cmd_timer
// Inter-byte timeout down-counter. Only instantiated by the bridge when
// GPIO_CMD_TIMEOUT_EN is defined.
//   i_clk    : system clock
//   i_rst    : synchronous active-high reset
//   i_clear  : reload to CYCLES-1
//   i_enable : count down (holds at zero)
//   o_expire : enabled and counter at zero, i.e. the CYCLES-th enabled cycle
//              since the last clear
// ---------------------------------------------------------------------------
module gpio_cmd_timer #(
    parameter int CYCLES = 600000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int W = $clog2(CYCLES);
    localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= LOAD;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_expire = i_enable && (r_count == '0);

endmodule

// File: rtl/gpio_cmd_bridge.sv
// ---------------------------------------------------------------------------
// gpio_cmd_bridge
// Decodes two-byte commands (mode, data) from the UART RX stream, writes the
// GPIO mode/data registers with a one-cycle strobe and, if any pin is an
// input, samples the pins and returns one status byte to UART TX.
// Ports:
//   i_clk         : system clock
//   i_rst         : synchronous active-high reset
//   bus           : gpio_cmd_bridge_if.slave (rx_*, gpio_*, tx_*)
//   o_busy        : high in every state except IDLE
//   o_err_timeout : one-cycle pulse when a command is aborted by timeout
//   o_drop_cnt    : saturating count of bytes discarded while busy
// Configuration macro: GPIO_CMD_TIMEOUT_EN builds the inter-byte timeout;
// without it WAIT_DATA waits indefinitely and o_err_timeout is tied low.
// ---------------------------------------------------------------------------
module gpio_cmd_bridge
    import gpio_cmd_pkg::*;
#(
    parameter int WIDTH_PIN      = 2,
    parameter int TIMEOUT_CYCLES = 600000,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    gpio_cmd_bridge_if.slave  bus,
    output logic              o_busy,
    output logic              o_err_timeout,
    output logic [7:0]        o_drop_cnt
);

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    gpio_cmd_state_t     r_state;
    gpio_cmd_state_t     w_state_next;
    logic [7:0]          r_mode_shadow;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic [7:0]          r_gpio_mode;
    logic [7:0]          r_gpio_data;
    logic                r_gpio_valid;
    logic [7:0]          r_tx_data;
    logic                r_tx_valid;
    logic                r_busy;
    logic [7:0]          r_drop_cnt;
    logic                w_timeout;
    logic                w_all_out;

    // All driven pins are outputs: nothing to read back.
    assign w_all_out = &r_mode_shadow[WIDTH_PIN-1:0];

`ifdef GPIO_CMD_TIMEOUT_EN
    logic r_err_timeout;

    // Held in reload outside WAIT_DATA, so it starts fresh on every entry.
    gpio_cmd_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (r_state != WAIT_DATA),
        .i_enable (r_state == WAIT_DATA),
        .o_expire (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_timeout <= 1'b0;
        end else begin
            // A byte arriving in the expiry cycle wins over the timeout.
            r_err_timeout <= (r_state == WAIT_DATA) && !bus.rx_valid && w_timeout;
        end
    end

    assign o_err_timeout = r_err_timeout;
`else
    assign w_timeout     = 1'b0;
    assign o_err_timeout = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its inputs, independent of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next state gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.rx_valid) w_state_next = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.rx_valid)   w_state_next = APPLY;
                else if (w_timeout) w_state_next = IDLE;
            end
            APPLY: begin
                w_state_next = w_all_out ? IDLE : SETTLE;
            end
            SETTLE: begin
                if (r_settle_cnt == '0) w_state_next = SAMPLE;
            end
            SAMPLE: begin
                w_state_next = SEND;
            end
            SEND: begin
                if (r_tx_valid && bus.tx_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mode_shadow <= '0;
            r_settle_cnt  <= '0;
            r_gpio_mode   <= GPIO_CMD_MODE_RESET;
            r_gpio_data   <= GPIO_CMD_DATA_RESET;
            r_gpio_valid  <= 1'b0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
            r_busy        <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_gpio_valid <= 1'b0;
            r_busy       <= (w_state_next != IDLE);

            case (r_state)
                IDLE: begin
                    if (bus.rx_valid) r_mode_shadow <= bus.rx_data;
                end
                WAIT_DATA: begin
                    // The data byte goes straight into the output register so
                    // the new mode/data are already visible in APPLY alongside
                    // the strobe. On timeout the mode shadow is simply left to
                    // be overwritten by the next command byte.
                    if (bus.rx_valid) begin
                        r_gpio_mode  <= r_mode_shadow;
                        r_gpio_data  <= bus.rx_data;
                        r_gpio_valid <= 1'b1;
                    end
                end
                APPLY: begin
                    r_settle_cnt <= SETTLE_W'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - SETTLE_W'(1);
                end
                SAMPLE: begin
                    r_tx_data  <= 8'(bus.gpio_rd[WIDTH_PIN-1:0]);
                    r_tx_valid <= 1'b1;
                end
                SEND: begin
                    if (r_tx_valid && bus.tx_ready) r_tx_valid <= 1'b0;
                end
                default: ;
            endcase

            if (bus.rx_valid && (r_state inside {APPLY, SETTLE, SAMPLE, SEND})) begin
                r_drop_cnt <= drop_inc(r_drop_cnt);
            end
        end
    end

    assign bus.gpio_mode  = {24'h0, r_gpio_mode};
    assign bus.gpio_data  = {24'h0, r_gpio_data};
    assign bus.gpio_valid = r_gpio_valid;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign o_busy         = r_busy;
    assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// ---------------------------------------------------------------------------
// tb_gpio_cmd_bridge
// Directed stimulus for gpio_cmd_bridge with a queue-based scoreboard: each
// command pushes its expected GPIO write, status byte and timeout pulse; a
// monitor on the falling edge pops and compares whenever the DUT presents one.
// Timeout scenarios depend on GPIO_CMD_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_gpio_cmd_bridge;

    localparam int WIDTH_PIN      = 2;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int SETTLE_CYCLES  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic       err_timeout;
    logic [7:0] drop_cnt;

    gpio_cmd_bridge_if bus_if ();

    gpio_cmd_bridge #(
        .WIDTH_PIN      (WIDTH_PIN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SETTLE_CYCLES  (SETTLE_CYCLES)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus_if),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .o_drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] mode;
        logic [7:0] data;
        int         cyc;
    } gpio_exp_t;

    typedef struct {
        logic [7:0] data;
        int         rise;
    } tx_exp_t;

    gpio_exp_t gpio_q[$];
    tx_exp_t   tx_q[$];
    int        to_q[$];

    // ---------------- monitor / scoreboard ----------------
    gpio_exp_t mon_g;
    logic      prev_txv = 1'b0;
    bit        last_hs  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_txv = 1'b0;
            last_hs  = 1'b0;
        end else begin
            if (bus_if.gpio_valid) begin
                if (gpio_q.size() == 0) begin
                    check("unexpected_gpio_valid", bus_if.gpio_valid, 1'b0);
                end else begin
                    mon_g = gpio_q.pop_front();
                    check("gpio_mode", bus_if.gpio_mode, {24'h0, mon_g.mode});
                    check("gpio_data", bus_if.gpio_data, {24'h0, mon_g.data});
                    check("gpio_valid_cycle", cyc, mon_g.cyc);
                end
            end

            if (last_hs) check("tx_valid_after_accept", bus_if.tx_valid, 1'b0);
            last_hs = 1'b0;

            if (bus_if.tx_valid) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_tx_valid", bus_if.tx_valid, 1'b0);
                end else begin
                    check("tx_data", bus_if.tx_data, tx_q[0].data);
                    if (!prev_txv) check("tx_rise_cycle", cyc, tx_q[0].rise);
                    if (bus_if.tx_ready) begin
                        void'(tx_q.pop_front());
                        last_hs = 1'b1;
                    end
                end
            end
            prev_txv = bus_if.tx_valid;

            if (err_timeout) begin
                if (to_q.size() == 0) check("unexpected_err_timeout", err_timeout, 1'b0);
                else                  check("err_timeout_cycle", cyc, to_q.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data  = b;
        bus_if.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rx_valid = 1'b0;
    endtask

    // Mode then data back to back; expected write lands the cycle after the
    // data byte, status byte rises 3+SETTLE_CYCLES cycles after it.
    task automatic command(input logic [7:0] mode, input logic [7:0] data,
                           input bit expect_tx, input logic [7:0] tx_byte);
        send_byte(mode);
        gpio_q.push_back('{mode: mode, data: data, cyc: cyc + 1});
        if (expect_tx) tx_q.push_back('{data: tx_byte, rise: cyc + 3 + SETTLE_CYCLES});
        send_byte(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst              = 1'b1;
        bus_if.rx_data   = 8'h00;
        bus_if.rx_valid  = 1'b0;
        bus_if.gpio_rd   = 32'h0;
        bus_if.tx_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("rst_gpio_mode",   bus_if.gpio_mode,  32'h3);
        check("rst_gpio_data",   bus_if.gpio_data,  32'h1);
        check("rst_gpio_valid",  bus_if.gpio_valid, 1'b0);
        check("rst_tx_data",     bus_if.tx_data,    8'h00);
        check("rst_tx_valid",    bus_if.tx_valid,   1'b0);
        check("rst_busy",        busy,              1'b0);
        check("rst_err_timeout", err_timeout,       1'b0);
        check("rst_drop_cnt",    drop_cnt,          8'h00);
        idle(2);

        // All pins outputs: write only, no status byte
        command(8'h03, 8'h02, 1'b0, 8'h00);
        idle(8);
        check("all_out_busy", busy, 1'b0);

        // Pin 1 input, immediate accept
        bus_if.gpio_rd  = 32'h2;
        bus_if.tx_ready = 1'b1;
        command(8'h01, 8'h00, 1'b1, 8'h02);
        idle(12);

        // Stalled TX with three dropped bytes meanwhile
        bus_if.tx_ready = 1'b0;
        command(8'h01, 8'h00, 1'b1, 8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        idle(46);
        check("stall_drop_cnt",  drop_cnt,         8'd3);
        check("stall_gpio_mode", bus_if.gpio_mode, 32'h1);
        check("stall_busy",      busy,             1'b1);
        bus_if.tx_ready = 1'b1;
        idle(5);
        check("stall_done_busy", busy, 1'b0);

        // All pins inputs; upper gpio_rd bits must not leak into the status
        bus_if.gpio_rd = 32'hFFFF_FFFD;
        command(8'h00, 8'h05, 1'b1, 8'h01);
        idle(12);

`ifdef GPIO_CMD_TIMEOUT_EN
        // Mode byte then silence: abort with one pulse, outputs untouched
        to_q.push_back(cyc + TIMEOUT_CYCLES + 1);
        send_byte(8'h03);
        idle(TIMEOUT_CYCLES + 5);
        check("to_gpio_mode", bus_if.gpio_mode, 32'h0);
        check("to_gpio_data", bus_if.gpio_data, 32'h5);
        check("to_busy",      busy,             1'b0);
        command(8'h03, 8'h01, 1'b0, 8'h00);
        idle(8);

        // Data byte in the expiry cycle is accepted, no timeout
        send_byte(8'h03);
        idle(TIMEOUT_CYCLES - 1);
        gpio_q.push_back('{mode: 8'h03, data: 8'h00, cyc: cyc + 1});
        send_byte(8'h00);
        idle(8);
        check("edge_busy", busy, 1'b0);
`else
        // No timeout built: WAIT_DATA waits indefinitely
        send_byte(8'h03);
        idle(TIMEOUT_CYCLES + 20);
        check("no_to_busy",      busy,             1'b1);
        check("no_to_gpio_mode", bus_if.gpio_mode, 32'h0);
        gpio_q.push_back('{mode: 8'h03, data: 8'h01, cyc: cyc + 1});
        send_byte(8'h01);
        idle(8);
`endif

        // Reset in the middle of SEND
        bus_if.gpio_rd  = 32'h2;
        bus_if.tx_ready = 1'b0;
        command(8'h01, 8'h00, 1'b1, 8'h02);
        k = 0;
        while (!bus_if.tx_valid && k < 20) begin
            idle(1);
            k++;
        end
        check("pre_rst_tx_valid", bus_if.tx_valid, 1'b1);
        send_byte(8'h55);
        check("pre_rst_drop_cnt", drop_cnt, 8'd4);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        tx_q.delete();
        check("mid_rst_tx_valid",  bus_if.tx_valid,  1'b0);
        check("mid_rst_busy",      busy,             1'b0);
        check("mid_rst_gpio_mode", bus_if.gpio_mode, 32'h3);
        check("mid_rst_gpio_data", bus_if.gpio_data, 32'h1);
        check("mid_rst_drop_cnt",  drop_cnt,         8'h00);
        bus_if.tx_ready = 1'b1;
        idle(2);

        // Normal decode after reset
        command(8'h03, 8'h02, 1'b0, 8'h00);
        idle(8);

        check("gpio_queue_empty", gpio_q.size(), 0);
        check("tx_queue_empty",   tx_q.size(),   0);
        check("to_queue_empty",   to_q.size(),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
